// File: rtl/sar_search.sv
// Successive-approximation search controller driving a 4-bit style magnitude comparator.
// Each probe drives a midpoint guess for one cycle, then samples the relation code.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [2:0]       iCmp,
    output logic [WIDTH-1:0] oGuess,
    output logic [2:0]       oCascade,
    output logic             oBusy,
    output logic             oDone,
    output logic             oFound,
    output logic             oError,
    output logic [WIDTH-1:0] oResult,
    output logic [3:0]       oSteps
);

    // Handshake: iStart is a level request accepted only in IDLE or DONE; while
    // oBusy=1 it is ignored. oDone is a single-cycle pulse marking the DONE state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } stateT;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    stateT            state, stateNxt;
    logic [WIDTH-1:0] lo, loNxt;
    logic [WIDTH-1:0] hi, hiNxt;
    logic [WIDTH-1:0] guessNxt;
    logic [WIDTH-1:0] resultNxt;
    logic             foundNxt;
    logic             errorNxt;
    logic             doneNxt;
    logic             busyNxt;
    logic [3:0]       stepsNxt;
    logic [WIDTH:0]   midSum;
    logic             startReq;

    // Extra bit keeps lo+hi from wrapping before the halving shift.
    assign midSum   = {1'b0, lo} + {1'b0, hi};
    assign startReq = iStart && ((state == IDLE) || (state == DONE));
    assign oCascade = 3'b000;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state   <= IDLE;
            lo      <= '0;
            hi      <= '0;
            oGuess  <= '0;
            oResult <= '0;
            oFound  <= 1'b0;
            oError  <= 1'b0;
            oDone   <= 1'b0;
            oBusy   <= 1'b0;
            oSteps  <= '0;
        end else begin
            state   <= stateNxt;
            lo      <= loNxt;
            hi      <= hiNxt;
            oGuess  <= guessNxt;
            oResult <= resultNxt;
            oFound  <= foundNxt;
            oError  <= errorNxt;
            oDone   <= doneNxt;
            oBusy   <= busyNxt;
            oSteps  <= stepsNxt;
        end
    end

    always_comb begin
        stateNxt  = state;
        loNxt     = lo;
        hiNxt     = hi;
        guessNxt  = oGuess;
        resultNxt = oResult;
        foundNxt  = oFound;
        errorNxt  = oError;
        stepsNxt  = oSteps;
        doneNxt   = 1'b0;

        case (state)
            IDLE: begin
                stateNxt = IDLE;
            end
            DRIVE: begin
                guessNxt = midSum[WIDTH:1];
                stateNxt = SAMPLE;
            end
            SAMPLE: begin
                stepsNxt = oSteps + 4'd1;
                case (iCmp)
                    3'b010: begin
                        resultNxt = oGuess;
                        foundNxt  = 1'b1;
                        stateNxt  = DONE;
                    end
                    3'b001: begin
                        if (oGuess == hi) begin
                            errorNxt = 1'b1;
                            stateNxt = DONE;
                        end else begin
                            loNxt    = oGuess + 1'b1;
                            stateNxt = DRIVE;
                        end
                    end
                    3'b100: begin
                        if (oGuess == lo) begin
                            errorNxt = 1'b1;
                            stateNxt = DONE;
                        end else begin
                            hiNxt    = oGuess - 1'b1;
                            stateNxt = DRIVE;
                        end
                    end
                    default: begin
                        errorNxt = 1'b1;
                        stateNxt = DONE;
                    end
                endcase
                doneNxt = (stateNxt == DONE);
            end
            DONE: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase

        // A start from IDLE or DONE reinitialises the range regardless of branch above.
        if (startReq) begin
            loNxt     = '0;
            hiNxt     = ALL_ONES;
            stepsNxt  = '0;
            foundNxt  = 1'b0;
            errorNxt  = 1'b0;
            resultNxt = '0;
            stateNxt  = DRIVE;
        end

        busyNxt = (stateNxt == DRIVE) || (stateNxt == SAMPLE);
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: behavioural comparator, immediate-assertion checks,
// hand-computed probe sequences plus an exhaustive sweep of all 4-bit targets.
module tb_sar_search;

    localparam int W = 4;

    logic         iClk;
    logic         iRst_n;
    logic         iStart;
    logic [2:0]   iCmp;
    logic [W-1:0] oGuess;
    logic [2:0]   oCascade;
    logic         oBusy;
    logic         oDone;
    logic         oFound;
    logic         oError;
    logic [W-1:0] oResult;
    logic [3:0]   oSteps;

    logic [W-1:0] target;
    logic         forceEn;
    logic [2:0]   forceVal;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit doneSeen;
    bit cascadeOk;
    logic [W-1:0] probes[$];
    logic [W-1:0] expQ[$];

    sar_search #(.WIDTH(W)) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iStart   (iStart),
        .iCmp     (iCmp),
        .oGuess   (oGuess),
        .oCascade (oCascade),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oFound   (oFound),
        .oError   (oError),
        .oResult  (oResult),
        .oSteps   (oSteps)
    );

    // Clock and reset defaults
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Behavioural comparator: A = target, B = oGuess
    always_comb begin
        if (forceEn)            iCmp = forceVal;
        else if (target > oGuess) iCmp = 3'b001;
        else if (target == oGuess) iCmp = 3'b010;
        else                    iCmp = 3'b100;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        @(negedge iClk);
        iStart = 1'b1;
    endtask

    // Caller raised iStart before the start edge; this samples every negedge after it.
    task automatic runSearch(input bit holdStart, input int pulseAt);
        @(negedge iClk);
        if (!holdStart) iStart = 1'b0;
        cyc = 1;
        doneSeen = 1'b0;
        cascadeOk = 1'b1;
        probes.delete();
        while (cyc <= 40) begin
            if (oCascade !== 3'b000) cascadeOk = 1'b0;
            if (oDone === 1'b1) begin
                doneSeen = 1'b1;
                break;
            end
            if ((cyc % 2 == 0) && oBusy) probes.push_back(oGuess);
            if (cyc == pulseAt) iStart = 1'b1;
            else if (!holdStart) iStart = 1'b0;
            @(negedge iClk);
            cyc++;
        end
    endtask

    task automatic checkSearch(input string tag, input bit expFound, input bit expError,
                               input int expResult, input int expSteps);
        check({tag, "_done_seen"}, doneSeen, 1);
        check({tag, "_latency"}, cyc, 2 * expSteps + 1);
        check({tag, "_probe_count"}, probes.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < probes.size(); i++)
            check($sformatf("%s_probe%0d", tag, i), probes[i], expQ[i]);
        check({tag, "_found"}, oFound, expFound);
        check({tag, "_error"}, oError, expError);
        check({tag, "_result"}, oResult, expResult);
        check({tag, "_steps"}, oSteps, expSteps);
        check({tag, "_busy_at_done"}, oBusy, 0);
        check({tag, "_cascade"}, cascadeOk, 1);
    endtask

    // Reference binary search used for the sweep expectations
    task automatic modelProbes(input int t);
        int lo, hi, g;
        lo = 0;
        hi = (1 << W) - 1;
        expQ.delete();
        for (int k = 0; k < 16; k++) begin
            g = (lo + hi) / 2;
            expQ.push_back(g[W-1:0]);
            if (t == g) break;
            else if (t > g) lo = g + 1;
            else hi = g - 1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_guess"}, oGuess, 0);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_done"}, oDone, 0);
        check({tag, "_found"}, oFound, 0);
        check({tag, "_error"}, oError, 0);
        check({tag, "_result"}, oResult, 0);
        check({tag, "_steps"}, oSteps, 0);
        check({tag, "_cascade"}, oCascade, 0);
    endtask

    initial begin
        iRst_n   = 1'b0;
        iStart   = 1'b0;
        target   = '0;
        forceEn  = 1'b0;
        forceVal = 3'b000;

        repeat (3) @(negedge iClk);
        checkAllZero("reset");
        iRst_n = 1'b1;
        @(negedge iClk);
        check("idle_busy", oBusy, 0);

        // Target 11: probes 7, 11
        target = 4'd11;
        expQ = '{4'd7, 4'd11};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("t11", 1'b1, 1'b0, 11, 2);

        // Target 0: probes 7, 3, 1, 0
        target = 4'd0;
        expQ = '{4'd7, 4'd3, 4'd1, 4'd0};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("t0", 1'b1, 1'b0, 0, 4);

        // Target 15: worst case, five probes
        target = 4'd15;
        expQ = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("t15", 1'b1, 1'b0, 15, 5);

        // Outputs hold in IDLE
        repeat (3) @(negedge iClk);
        check("hold_guess", oGuess, 15);
        check("hold_result", oResult, 15);
        check("hold_found", oFound, 1);
        check("hold_steps", oSteps, 5);
        check("hold_done", oDone, 0);
        check("hold_busy", oBusy, 0);

        // Exhaustive sweep
        for (int t = 0; t < 16; t++) begin
            target = t[W-1:0];
            modelProbes(t);
            pulseStart();
            runSearch(1'b0, 0);
            checkSearch($sformatf("sweep%0d", t), 1'b1, 1'b0, t, expQ.size());
            check($sformatf("sweep%0d_steps_le5", t), (oSteps <= 4'd5), 1);
        end

        // Invalid code at the first sample
        target = 4'd9;
        forceEn = 1'b1;
        forceVal = 3'b011;
        expQ = '{4'd7};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("bad_code", 1'b0, 1'b1, 0, 1);
        forceEn = 1'b0;

        // Clean search afterwards clears the error
        target = 4'd5;
        expQ = '{4'd7, 4'd3, 4'd5};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("after_err", 1'b1, 1'b0, 5, 3);

        // Comparator always says target<guess: empty range at guess 0 with lo=0
        forceEn = 1'b1;
        forceVal = 3'b100;
        expQ = '{4'd7, 4'd3, 4'd1, 4'd0};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("empty_low", 1'b0, 1'b1, 0, 4);

        // Comparator always says target>guess: empty range at guess 15 with hi=15
        forceVal = 3'b001;
        expQ = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("empty_high", 1'b0, 1'b1, 0, 5);
        forceEn = 1'b0;

        // Start pulse while busy is ignored
        target = 4'd9;
        expQ = '{4'd7, 4'd11, 4'd9};
        pulseStart();
        runSearch(1'b0, 2);
        checkSearch("busy_start", 1'b1, 1'b0, 9, 3);

        // iStart held through DONE gives a back-to-back search
        target = 4'd3;
        expQ = '{4'd7, 4'd3};
        pulseStart();
        runSearch(1'b1, 0);
        checkSearch("b2b_first", 1'b1, 1'b0, 3, 2);
        target = 4'd12;
        expQ = '{4'd7, 4'd11, 4'd13, 4'd12};
        runSearch(1'b0, 0);
        checkSearch("b2b_second", 1'b1, 1'b0, 12, 4);

        // Reset in the middle of a search
        target = 4'd0;
        pulseStart();
        @(negedge iClk);
        iStart = 1'b0;
        repeat (2) @(negedge iClk);
        iRst_n = 1'b0;
        @(negedge iClk);
        checkAllZero("mid_reset");
        iRst_n = 1'b1;
        @(negedge iClk);
        check("post_reset_done", oDone, 0);
        check("post_reset_busy", oBusy, 0);

        target = 4'd6;
        expQ = '{4'd7, 4'd3, 4'd5, 4'd6};
        pulseStart();
        runSearch(1'b0, 0);
        checkSearch("post_reset", 1'b1, 1'b0, 6, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
